// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: a shift register of in-flight destinations drives stall and forward selects
// from Tuse/Tnew, and a built-in mult/div busy counter covers the hi/lo unit.
module hazard_scoreboard #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned STAGES      = 3,
  parameter int unsigned TNEW_W      = 2,
  parameter int unsigned FWD_W       = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_W-1:0]  d_rs,
  input  logic [REG_W-1:0]  d_rt,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [REG_W-1:0]  d_wa,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [1:0]        d_md_kind,
  output logic              stall,
  output logic [FWD_W-1:0]  fwd_rs_sel,
  output logic [FWD_W-1:0]  fwd_rt_sel,
  output logic              md_busy
);

  localparam logic [1:0] MdMult = 2'd1;
  localparam logic [1:0] MdDiv  = 2'd2;

  // Index i holds pipeline stage i+1 (0 = E).
  logic [REG_W-1:0]  wa_q   [STAGES];
  logic [TNEW_W-1:0] tnew_q [STAGES];
  logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;

  logic [REG_W-1:0]  src       [2];
  logic [TNEW_W-1:0] tuse      [2];
  logic [FWD_W-1:0]  hit_stage [2];
  logic [TNEW_W-1:0] hit_tnew  [2];
  logic [FWD_W-1:0]  fwd_sel   [2];
  logic [1:0]        src_haz;
  logic              md_rule;
  logic              issue;

  assign src[0]  = d_rs;
  assign src[1]  = d_rt;
  assign tuse[0] = d_tuse_rs;
  assign tuse[1] = d_tuse_rt;

  // Scan oldest to youngest so the youngest matching stage is the one left standing.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit_stage[s] = '0;
      hit_tnew[s]  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (src[s] != '0 && wa_q[k] == src[s]) begin
          hit_stage[s] = FWD_W'(k + 1);
          hit_tnew[s]  = tnew_q[k];
        end
      end
      src_haz[s] = (hit_stage[s] != '0) && (tuse[s] != '1) && (hit_tnew[s] > tuse[s]);
      fwd_sel[s] = (hit_stage[s] != '0 && hit_tnew[s] == '0) ? hit_stage[s] : '0;
    end
  end

  assign md_rule    = d_valid && (d_md_kind != 2'd0) && (md_cnt_q != '0);
  assign stall      = d_valid && ((|src_haz) || md_rule);
  assign issue      = d_valid && !stall;
  assign fwd_rs_sel = fwd_sel[0];
  assign fwd_rt_sel = fwd_sel[1];
  assign md_busy    = (md_cnt_q != '0);

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (issue && d_md_kind == MdMult) begin
      md_cnt_d = CNT_W'(MULT_CYCLES);
    end else if (issue && d_md_kind == MdDiv) begin
      md_cnt_d = CNT_W'(DIV_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        wa_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
      md_cnt_q <= '0;
    end else begin
      wa_q[0]   <= issue ? d_wa : '0;
      tnew_q[0] <= issue ? d_tnew : '0;
      for (int k = 1; k < STAGES; k++) begin
        wa_q[k]   <= wa_q[k-1];
        tnew_q[k] <= (tnew_q[k-1] != '0) ? tnew_q[k-1] - TNEW_W'(1) : '0;
      end
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a table of per-cycle vectors plus hand-written md and reset
// sequences; expected outputs are queued when a vector is driven and popped when sampled.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_kind;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_wa      (d_wa),
    .d_tnew    (d_tnew),
    .d_md_kind (d_md_kind),
    .stall     (stall),
    .fwd_rs_sel(fwd_rs_sel),
    .fwd_rt_sel(fwd_rt_sel),
    .md_busy   (md_busy)
  );

  typedef struct {
    string      name;
    logic       valid;
    logic [4:0] rs;
    logic [1:0] tuse_rs;
    logic [4:0] rt;
    logic [1:0] tuse_rt;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic [1:0] kind;
    logic       exp_stall;
    logic [1:0] exp_fwd_rs;
    logic [1:0] exp_fwd_rt;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[17];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic v, logic [4:0] rs, logic [1:0] urs,
                              logic [4:0] rt, logic [1:0] urt, logic [4:0] wa,
                              logic [1:0] tn, logic [1:0] k, logic st, logic [1:0] frs,
                              logic [1:0] frt, logic b);
    vec_t r;
    r.name = n;    r.valid = v;      r.rs = rs;          r.tuse_rs = urs;
    r.rt = rt;     r.tuse_rt = urt;  r.wa = wa;          r.tnew = tn;
    r.kind = k;    r.exp_stall = st; r.exp_fwd_rs = frs; r.exp_fwd_rt = frt;
    r.exp_busy = b;
    return r;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of D inputs (called at posedge+1), check at negedge, return at posedge+1.
  task automatic step(input vec_t v);
    vec_t e;
    d_valid   = v.valid;
    d_rs      = v.rs;
    d_rt      = v.rt;
    d_tuse_rs = v.tuse_rs;
    d_tuse_rt = v.tuse_rt;
    d_wa      = v.wa;
    d_tnew    = v.tnew;
    d_md_kind = v.kind;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({e.name, ".stall"},  {3'b0, stall},      {3'b0, e.exp_stall});
    chk({e.name, ".fwd_rs"}, {2'b0, fwd_rs_sel}, {2'b0, e.exp_fwd_rs});
    chk({e.name, ".fwd_rt"}, {2'b0, fwd_rt_sel}, {2'b0, e.exp_fwd_rt});
    chk({e.name, ".busy"},   {3'b0, md_busy},    {3'b0, e.exp_busy});
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                n                  v rs urs rt urt wa tn k   st frs frt b
    vecs[0]  = mk("reset_state",      0, 0, 3, 0, 3, 0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = mk("lw_issue",         1, 0, 3, 0, 3, 8, 2, 0,  0, 0, 0, 0);
    vecs[2]  = mk("load_use_stall",   1, 8, 1, 0, 3, 9, 1, 0,  1, 0, 0, 0);
    vecs[3]  = mk("load_use_go",      1, 8, 1, 0, 3, 9, 1, 0,  0, 0, 0, 0);
    vecs[4]  = mk("addu_issue",       1, 8, 3, 0, 3, 5, 1, 0,  0, 3, 0, 0);
    vecs[5]  = mk("beq_stall",        1, 5, 0, 5, 0, 0, 0, 0,  1, 0, 0, 0);
    vecs[6]  = mk("beq_fwd",          1, 5, 0, 5, 0, 0, 0, 0,  0, 2, 2, 0);
    vecs[7]  = mk("wr3_a",            1, 0, 3, 5, 3, 3, 1, 0,  0, 0, 3, 0);
    vecs[8]  = mk("wr3_b",            1, 0, 3, 0, 3, 3, 1, 0,  0, 0, 0, 0);
    vecs[9]  = mk("youngest_wins",    1, 3, 0, 3, 3, 0, 0, 0,  1, 0, 0, 0);
    vecs[10] = mk("youngest_fwd",     1, 3, 0, 3, 3, 0, 0, 0,  0, 2, 2, 0);
    vecs[11] = mk("wa0_issue",        1, 0, 3, 0, 3, 0, 2, 0,  0, 0, 0, 0);
    vecs[12] = mk("zero_src",         1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[13] = mk("wr7",              1, 0, 3, 0, 3, 7, 2, 0,  0, 0, 0, 0);
    vecs[14] = mk("bubble_no_stall",  0, 7, 0, 0, 3, 0, 0, 0,  0, 0, 0, 0);
    vecs[15] = mk("stall_s2",         1, 7, 0, 0, 3, 0, 0, 0,  1, 0, 0, 0);
    vecs[16] = mk("fwd_s3",           1, 7, 0, 0, 3, 0, 0, 0,  0, 3, 0, 0);

    reset     = 1'b1;
    d_valid   = 1'b0;
    d_rs      = '0;
    d_rt      = '0;
    d_tuse_rs = '1;
    d_tuse_rt = '1;
    d_wa      = '0;
    d_tnew    = '0;
    d_md_kind = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) step(vecs[i]);

    // div then mflo: ten stalled cycles, issue on the eleventh.
    step(mk("div_issue",       1, 0, 3, 0, 3, 0, 0, 2,  0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      step(mk("mflo_stall",    1, 0, 3, 0, 3, 2, 1, 3,  1, 0, 0, 1));
    step(mk("mflo_issue",      1, 0, 3, 0, 3, 2, 1, 3,  0, 0, 0, 0));
    step(mk("mult_issue",      1, 0, 3, 0, 3, 0, 0, 1,  0, 0, 0, 0));
    step(mk("addu_after_mult", 1, 0, 3, 0, 3, 5, 1, 0,  0, 0, 0, 1));
    step(mk("multu_busy",      1, 0, 3, 0, 3, 0, 0, 1,  1, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      step(mk("mult_drain",    0, 0, 3, 0, 3, 0, 0, 0,  0, 0, 0, 1));
    step(mk("mult_done",       0, 0, 3, 0, 3, 0, 0, 0,  0, 0, 0, 0));

    // Build stage 1 tnew=2 with md_cnt=7, then reset mid-flight.
    step(mk("div_issue2",      1, 0, 3, 0, 3, 0, 0, 2,  0, 0, 0, 0));
    for (int i = 0; i < 2; i++)
      step(mk("div_wait",      0, 0, 3, 0, 3, 0, 0, 0,  0, 0, 0, 1));
    step(mk("wr4",             1, 0, 3, 0, 3, 4, 2, 0,  0, 0, 0, 1));
    reset = 1'b1;
    step(mk("in_reset",        1, 4, 0, 4, 0, 0, 0, 3,  1, 0, 0, 1));
    reset = 1'b0;
    step(mk("after_reset",     1, 4, 0, 4, 0, 0, 0, 3,  0, 0, 0, 0));

    chk("queue_drained", 4'(exp_q.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
